// File: rtl/sync_fifo_if.sv
`default_nettype none
// ============================================================================
// Module   : sync_fifo_if
// Brief    : Valid/ready write and read channels plus occupancy for sync_fifo.
// Revision : 1.0 - initial release
// ============================================================================
interface sync_fifo_if #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
);
  localparam int c_CNT_W = $clog2(DEPTH + 1);

  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   in;
  logic               out_valid;
  logic               out_ready;
  logic [WIDTH-1:0]   out;
  logic [c_CNT_W-1:0] count;

  modport master (
    output in_valid, in, out_ready,
    input  in_ready, out_valid, out, count
  );

  modport slave (
    input  in_valid, in, out_ready,
    output in_ready, out_valid, out, count
  );
endinterface
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// ============================================================================
// Module   : sync_fifo
// Brief    : Single-clock valid/ready FIFO, power-of-two depth, 1-cycle latency.
//            Define SYNC_FIFO_BYPASS_EN for the combinational empty bypass.
// Revision : 1.0 - initial release
// ============================================================================
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  sync_fifo_if.slave  bus
);
  localparam int c_ADDR_W = $clog2(DEPTH);
  localparam int c_CNT_W  = $clog2(DEPTH + 1);
  localparam logic [c_CNT_W-1:0] c_FULL = c_CNT_W'(DEPTH);

  logic [WIDTH-1:0]    r_mem [DEPTH];
  logic [c_ADDR_W-1:0] r_wr_ptr;
  logic [c_ADDR_W-1:0] r_rd_ptr;
  logic [c_CNT_W-1:0]  r_count;

  logic w_empty;
  logic w_full;
  logic w_push;
  logic w_pop;

  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == c_FULL);

  assign bus.in_ready = !w_full;
  assign bus.count    = r_count;

  always_comb begin
    bus.out_valid = !w_empty;
    bus.out       = r_mem[r_rd_ptr];
    w_push        = bus.in_valid && !w_full;
    w_pop         = !w_empty && bus.out_ready;
`ifdef SYNC_FIFO_BYPASS_EN
    // Empty FIFO forwards the input word; storing it only if nobody takes it now.
    if (w_empty) begin
      bus.out_valid = bus.in_valid;
      bus.out       = bus.in;
      w_push        = bus.in_valid && !bus.out_ready;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push && !reset) begin
      r_mem[r_wr_ptr] <= bus.in;
    end
  end
endmodule
`default_nettype wire
